// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - run controller and commit monitor for the pipelined core
//
// Holds the core in reset for HOLD_CYCLES edges after system reset, then lets
// it run while counting cycles and register writebacks and mirroring R0-R14
// into a shadow register file. The run ends in PASS or FAIL when the core
// stores to DONE_ADDR, or in TIMEOUT when the cycle budget is used up.
//
// Ports:
//   clk         system clock, rising-edge
//   reset       asynchronous active-low system reset
//   RegWrite    writeback-stage register write enable
//   A3          writeback destination register index (15 = PC, not stored)
//   WD3         writeback data
//   MemWrite    memory-stage data write strobe
//   DataAdr     data-memory address
//   WriteData   data-memory write data
//   rd_addr     shadow register readback index
//   core_reset  active-high reset to the core (low only while running)
//   rd_data     shadow register contents at rd_addr (0 for index 15)
//   cycle_count RUN cycles elapsed
//   wb_count    retired register writes
//   status      HOLD=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4
//   done        run has finished (PASS, FAIL or TIMEOUT)
//   pass        run finished with PASS

module run_monitor #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_0064,
    parameter logic [31:0] EXPECT_DATA = 32'd7,
    parameter logic [31:0] MAX_CYCLES  = 32'd60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [3:0]  A3,
    input  logic [31:0] WD3,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [3:0]  rd_addr,
    output logic        core_reset,
    output logic [31:0] rd_data,
    output logic [31:0] cycle_count,
    output logic [31:0] wb_count,
    output logic [2:0]  status,
    output logic        done,
    output logic        pass
);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    // A HOLD_CYCLES of 0 degenerates to a single hold edge.
    localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES > 0) ? 32'(HOLD_CYCLES - 1) : 32'd0;
    // cycle_count value on the edge that would take it to MAX_CYCLES.
    localparam logic [31:0] CYC_LAST  = MAX_CYCLES - 32'd1;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] hold_cnt;
    logic [31:0] shadow [0:14];

    logic in_run;
    logic completion;
    logic wb_store;

    assign in_run     = (state == ST_RUN);
    assign completion = in_run && MemWrite && (DataAdr == DONE_ADDR);
    assign wb_store   = in_run && RegWrite && (A3 != 4'd15);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A completion store on the budget's last edge wins over timeout.
                if (completion) begin
                    state_nxt = (WriteData == EXPECT_DATA) ? ST_PASS : ST_FAIL;
                end else if (cycle_count == CYC_LAST) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            default: begin
                // PASS, FAIL and TIMEOUT are terminal until reset.
                state_nxt = state;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hold counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= 32'd0;
        end else if (state == ST_HOLD) begin
            hold_cnt <= hold_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Run counters; they freeze outside RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'd0;
            wb_count    <= 32'd0;
        end else if (in_run) begin
            cycle_count <= cycle_count + 32'd1;
            if (RegWrite) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow register file R0-R14; PC writebacks are counted, not stored.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) begin
                shadow[i] <= 32'd0;
            end
        end else if (wb_store) begin
            shadow[A3] <= WD3;
        end
    end

    assign rd_data = (rd_addr == 4'd15) ? 32'd0 : shadow[rd_addr];

    // ------------------------------------------------------------------
    // Outputs decode only the state register, so nothing from the core
    // inputs reaches them combinationally.
    // ------------------------------------------------------------------
    assign status     = state;
    assign core_reset = !in_run;
    assign done       = (state == ST_PASS) || (state == ST_FAIL) || (state == ST_TIMEOUT);
    assign pass       = (state == ST_PASS);

endmodule
